// File: rtl/lmu_lqsignacc.sv
// lmu_lqsignacc: per-LQ Z/X sign accumulators that sit after lmu_lqsigngen.
// Interpret patches XOR-fold their temp sign lists into the accumulators.
// LQM patches pass their bits straight through. Each finalized
// (lqaddr, signZ, signX) is queued in a small output FIFO, which is drained
// by a valid/ready handshake.
module lmu_lqsignacc #(
  parameter int NUM_LQ     = 4,
  parameter int LQADDR_BW  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_start,
  input  logic                 acc_end,
  input  logic                 pchinfo_valid,
  input  logic                 interp_mode,
  input  logic                 lqsign_valid,
  input  logic [LQADDR_BW-1:0] lqsign_valid_idx,
  input  logic [NUM_LQ-1:0]    lqsignZ_temp_list,
  input  logic [NUM_LQ-1:0]    lqsignX_temp_list,
  output logic [NUM_LQ-1:0]    lqsignZ_acc_reg,
  output logic [NUM_LQ-1:0]    lqsignX_acc_reg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LQADDR_BW-1:0] out_lqaddr,
  output logic                 out_signZ,
  output logic                 out_signX,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [LQADDR_BW-1:0] lqaddr;
    logic                 sign_z;
    logic                 sign_x;
  } entry_t;

  state_e            state_q;
  logic              seq_done_q;
  logic              ovf_q;
  logic [NUM_LQ-1:0] acc_z_q, acc_z_d;
  logic [NUM_LQ-1:0] acc_x_q, acc_x_d;
  entry_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic   fold_en;
  logic   push_req;
  logic   push_ok;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t push_entry;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = out_valid & out_ready;
  assign push_ok    = push_req & (~fifo_full | pop);

  // Fold/push decode. Interpret entries capture the post-fold accumulator bit,
  // so a patch that both folds and finalizes reports its own contribution.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fold_en    = pchinfo_valid & interp_mode & (state_q == S_ACCUM);
    acc_z_d    = (acc_start ? '0 : acc_z_q) ^ (fold_en ? lqsignZ_temp_list : '0);
    acc_x_d    = (acc_start ? '0 : acc_x_q) ^ (fold_en ? lqsignX_temp_list : '0);
    push_req   = pchinfo_valid & lqsign_valid &
                 (~interp_mode | (state_q == S_ACCUM));
    push_entry = '{lqaddr: lqsign_valid_idx,
                   sign_z: interp_mode ? acc_z_d[lqsign_valid_idx]
                                       : lqsignZ_temp_list[lqsign_valid_idx],
                   sign_x: interp_mode ? acc_x_d[lqsign_valid_idx]
                                       : lqsignX_temp_list[lqsign_valid_idx]};
  end

  // Sequence FSM with the registered seq_done pulse on FLUSH->IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seq_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      seq_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc_start) state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (acc_start)    state_q <= S_ACCUM;
          else if (acc_end) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (acc_start) begin
            state_q <= S_ACCUM;
          end else if (fifo_empty && !push_req) begin
            state_q    <= S_IDLE;
            seq_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Z/X accumulators, fed back to lmu_lqsigngen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_z_q <= '0;
      acc_x_q <= '0;
    end else begin
      acc_z_q <= acc_z_d;
      acc_x_q <= acc_x_d;
    end
  end

  // Output FIFO: storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset as well because the head is presented
      // directly on the outputs, which must read 0 while in reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign lqsignZ_acc_reg = acc_z_q;
  assign lqsignX_acc_reg = acc_x_q;
  assign out_valid       = ~fifo_empty;
  assign out_lqaddr      = mem_q[rd_ptr_q].lqaddr;
  assign out_signZ       = mem_q[rd_ptr_q].sign_z;
  assign out_signX       = mem_q[rd_ptr_q].sign_x;
  assign busy            = (state_q != S_IDLE);
  assign seq_done        = seq_done_q;
  assign ovf             = ovf_q;

endmodule

// File: tb/tb_lmu_lqsignacc.sv
// Directed bench for lmu_lqsignacc: accumulate, finalize, flush, LQM
// passthrough, asynchronous reset, FIFO backpressure/overflow and
// push-with-pop at full.
module tb_lmu_lqsignacc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       acc_start, acc_end, pchinfo_valid, interp_mode, lqsign_valid;
  logic [1:0] lqsign_valid_idx;
  logic [3:0] lqsignZ_temp_list, lqsignX_temp_list;
  logic [3:0] lqsignZ_acc_reg, lqsignX_acc_reg;
  logic       out_valid, out_ready, out_signZ, out_signX;
  logic [1:0] out_lqaddr;
  logic       busy, seq_done, ovf;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;

  lmu_lqsignacc #(.NUM_LQ(4), .LQADDR_BW(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_start(acc_start), .acc_end(acc_end),
    .pchinfo_valid(pchinfo_valid), .interp_mode(interp_mode),
    .lqsign_valid(lqsign_valid), .lqsign_valid_idx(lqsign_valid_idx),
    .lqsignZ_temp_list(lqsignZ_temp_list), .lqsignX_temp_list(lqsignX_temp_list),
    .lqsignZ_acc_reg(lqsignZ_acc_reg), .lqsignX_acc_reg(lqsignX_acc_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_lqaddr(out_lqaddr),
    .out_signZ(out_signZ), .out_signX(out_signX),
    .busy(busy), .seq_done(seq_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Count every cycle in which seq_done is seen high.
  always @(negedge clk) if (rst_n && seq_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_head(input string tag, input logic [1:0] idx, input logic z,
                            input logic x);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".lqaddr"}, 32'(out_lqaddr), 32'(idx));
    check({tag, ".signZ"}, 32'(out_signZ), 32'(z));
    check({tag, ".signX"}, 32'(out_signX), 32'(x));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_start         = 1'b0;
    acc_end           = 1'b0;
    pchinfo_valid     = 1'b0;
    interp_mode       = 1'b0;
    lqsign_valid      = 1'b0;
    lqsign_valid_idx  = 2'd0;
    lqsignZ_temp_list = 4'b0000;
    lqsignX_temp_list = 4'b0000;
  endtask

  task automatic interp_patch(input logic [3:0] tz, input logic [3:0] tx);
    pchinfo_valid     = 1'b1;
    interp_mode       = 1'b1;
    lqsign_valid      = 1'b0;
    lqsignZ_temp_list = tz;
    lqsignX_temp_list = tx;
  endtask

  task automatic lqm_push(input logic [1:0] idx, input logic z, input logic x);
    pchinfo_valid     = 1'b1;
    interp_mode       = 1'b0;
    lqsign_valid      = 1'b1;
    lqsign_valid_idx  = idx;
    lqsignZ_temp_list = 4'(z) << idx;
    lqsignX_temp_list = 4'(x) << idx;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.seq_done", 32'(seq_done), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.accZ", 32'(lqsignZ_acc_reg), 32'd0);
    check("rst.accX", 32'(lqsignX_acc_reg), 32'd0);
    check("rst.lqaddr", 32'(out_lqaddr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Accumulate: three interpret patches, no finalization.
    acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    check("acc.busy", 32'(busy), 32'd1);
    interp_patch(4'b0101, 4'b0001);
    tick();
    check("acc.p1.X", 32'(lqsignX_acc_reg), 32'b0001);
    interp_patch(4'b0000, 4'b0011);
    tick();
    check("acc.p2.X", 32'(lqsignX_acc_reg), 32'b0010);
    interp_patch(4'b0000, 4'b0001);
    tick();
    check("acc.p3.X", 32'(lqsignX_acc_reg), 32'b0011);
    check("acc.p3.Z", 32'(lqsignZ_acc_reg), 32'b0101);
    check("acc.no_push", 32'(out_valid), 32'd0);

    // Bring accX to 0100, then finalize LQ 2 with the fold in the same patch.
    interp_patch(4'b0000, 4'b0111);
    tick();
    check("fin.pre.X", 32'(lqsignX_acc_reg), 32'b0100);
    interp_patch(4'b0100, 4'b0100);
    lqsign_valid     = 1'b1;
    lqsign_valid_idx = 2'd2;
    tick();
    check_head("fin.entry", 2'd2, 1'b0, 1'b0);
    check("fin.X", 32'(lqsignX_acc_reg), 32'b0000);
    check("fin.Z", 32'(lqsignZ_acc_reg), 32'b0001);

    // Second queued entry via LQM passthrough; head must not move.
    lqm_push(2'd1, 1'b1, 1'b1);
    tick();
    check_head("q2.head", 2'd2, 1'b0, 1'b0);
    check("q2.Z", 32'(lqsignZ_acc_reg), 32'b0001);

    // Flush with two queued entries and the consumer ready.
    idle_inputs();
    acc_end   = 1'b1;
    out_ready = 1'b1;
    tick();
    acc_end = 1'b0;
    check("flush.c1.busy", 32'(busy), 32'd1);
    check_head("flush.c1.head", 2'd1, 1'b1, 1'b1);
    interp_patch(4'b1111, 4'b1111);
    tick();
    idle_inputs();
    check("flush.c2.busy", 32'(busy), 32'd1);
    check("flush.c2.Z", 32'(lqsignZ_acc_reg), 32'b0001);
    check("flush.c2.X", 32'(lqsignX_acc_reg), 32'b0000);
    check("flush.c2.empty", 32'(out_valid), 32'd0);
    check("flush.c2.seq_done", 32'(seq_done), 32'd0);
    tick();
    check("flush.idle.busy", 32'(busy), 32'd0);
    check("flush.idle.seq_done", 32'(seq_done), 32'd1);
    tick();
    check("flush.after.seq_done", 32'(seq_done), 32'd0);
    tick();
    check("flush.done_cnt", 32'(done_cnt), 32'd1);
    out_ready = 1'b0;

    // LQM passthrough while IDLE.
    lqm_push(2'd3, 1'b1, 1'b0);
    tick();
    idle_inputs();
    check_head("lqm.entry", 2'd3, 1'b1, 1'b0);
    check("lqm.Z", 32'(lqsignZ_acc_reg), 32'b0001);
    check("lqm.X", 32'(lqsignX_acc_reg), 32'b0000);
    check("lqm.busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lqm.popped", 32'(out_valid), 32'd0);

    // Asynchronous reset in ACCUM with two FIFO entries.
    acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    interp_patch(4'b1010, 4'b0110);
    tick();
    lqm_push(2'd0, 1'b1, 1'b1);
    tick();
    lqm_push(2'd1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    check("arst.pre.valid", 32'(out_valid), 32'd1);
    check("arst.pre.Z", 32'(lqsignZ_acc_reg), 32'b1010);
    #3 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.Z", 32'(lqsignZ_acc_reg), 32'd0);
    check("arst.X", 32'(lqsignX_acc_reg), 32'd0);
    check("arst.lqaddr", 32'(out_lqaddr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst.after.valid", 32'(out_valid), 32'd0);

    // Backpressure: five pushes into a 4-deep FIFO with the consumer stalled.
    lqm_push(2'd0, 1'b1, 1'b0);
    tick();
    lqm_push(2'd1, 1'b0, 1'b1);
    tick();
    lqm_push(2'd2, 1'b1, 1'b1);
    tick();
    lqm_push(2'd3, 1'b0, 1'b0);
    tick();
    check("bp.ovf_before", 32'(ovf), 32'd0);
    lqm_push(2'd0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    check("bp.ovf", 32'(ovf), 32'd1);
    check_head("bp.head", 2'd0, 1'b1, 1'b0);
    tick();
    check_head("bp.stable", 2'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    check_head("bp.pop1", 2'd1, 1'b0, 1'b1);
    tick();
    check_head("bp.pop2", 2'd2, 1'b1, 1'b1);
    tick();
    check_head("bp.pop3", 2'd3, 1'b0, 1'b0);
    tick();
    check("bp.drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // At full, a push with a same-cycle pop is accepted.
    lqm_push(2'd0, 1'b0, 1'b0);
    tick();
    lqm_push(2'd1, 1'b1, 1'b0);
    tick();
    lqm_push(2'd2, 1'b0, 1'b1);
    tick();
    lqm_push(2'd3, 1'b1, 1'b1);
    tick();
    check_head("full.head", 2'd0, 1'b0, 1'b0);
    lqm_push(2'd2, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    idle_inputs();
    check_head("full.pp1", 2'd1, 1'b1, 1'b0);
    tick();
    check_head("full.pp2", 2'd2, 1'b0, 1'b1);
    tick();
    check_head("full.pp3", 2'd3, 1'b1, 1'b1);
    tick();
    check_head("full.pp4", 2'd2, 1'b1, 1'b0);
    tick();
    check("full.drained", 32'(out_valid), 32'd0);
    check("full.ovf_sticky", 32'(ovf), 32'd1);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
